// File: rtl/tt3_sweep_capture_if.sv
// Handshake and result bundle between the sweep sequencer and its controller/gate.
interface tt3_sweep_capture_if;
   logic       start;
   logic       abort;
   logic       gate_out;
   logic       in1;
   logic       in2;
   logic       in3;
   logic       busy;
   logic       done;
   logic [7:0] tt;
   logic [7:0] unstable;
   logic       match;

   // Controller / gate side: issues requests, supplies the gate output.
   modport master (
      output start, abort, gate_out,
      input  in1, in2, in3, busy, done, tt, unstable, match
   );

   // Sequencer side.
   modport slave (
      input  start, abort, gate_out,
      output in1, in2, in3, busy, done, tt, unstable, match
   );
endinterface

// File: rtl/tt3_sweep_capture.sv
// Truth-table sweep sequencer: drives rows 000..111 into a 3-input gate,
// samples its synchronised output per row and reports the 8-bit word.
module tt3_sweep_capture #(
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned STABLE_CYCLES = 2,
   parameter int unsigned SYNC_STAGES   = 2,
   parameter logic [7:0]  EXPECTED_TT   = 8'h64
) (
   input logic                clk,
   input logic                rst_n,
   tt3_sweep_capture_if.slave bus
);

   localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   // Row window must cover the synchroniser latency plus the stable window.
   if (SETTLE_CYCLES < SYNC_STAGES + STABLE_CYCLES) begin : g_bad_settle
      $error("SETTLE_CYCLES must be >= SYNC_STAGES + STABLE_CYCLES");
   end
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("SYNC_STAGES must be >= 2");
   end

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      FINISH = 2'd2
   } state_e;

   state_e                 state_q;
   logic [2:0]             row_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [2:0]             drive_q;
   logic                   busy_q;
   logic                   done_q;
   logic [7:0]             tt_q;
   logic [7:0]             unstable_q;
   logic                   match_q;
   logic [7:0]             sh_tt_q;
   logic [7:0]             sh_unst_q;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_prev_q;

   logic [7:0]             sh_tt_d;
   logic [7:0]             sh_unst_d;
   logic                   synced_c;
   logic                   cnt_last_c;
   logic                   in_window_c;
   logic                   changed_c;
   logic [2:0]             bit_idx_c;

   assign synced_c    = sync_q[SYNC_STAGES-1];
   assign cnt_last_c  = (cnt_q == CNT_W'(SETTLE_CYCLES - 1));
   // Only transitions between two cycles that both lie in the stable window
   // count; the row's own settling edge lands on the first window cycle.
   assign in_window_c = (cnt_q > CNT_W'(SETTLE_CYCLES - STABLE_CYCLES));
   assign changed_c   = (synced_c != sync_prev_q);
   assign bit_idx_c   = ~row_q;

   // Synchronise the asynchronous gate output; keep last cycle's synced value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q      <= '0;
         sync_prev_q <= 1'b0;
      end else begin
         sync_q      <= {sync_q[SYNC_STAGES-2:0], bus.gate_out};
         sync_prev_q <= synced_c;
      end
   end

   // Shadow word including this cycle's capture / instability update.
   always_comb begin
      sh_tt_d   = sh_tt_q;
      sh_unst_d = sh_unst_q;
      if (cnt_last_c) begin
         sh_tt_d[bit_idx_c] = synced_c;
      end
      if (in_window_c && changed_c) begin
         sh_unst_d[bit_idx_c] = 1'b1;
      end
   end

   // Sweep FSM; results are committed on entry to FINISH so they are visible with done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         row_q      <= '0;
         cnt_q      <= '0;
         drive_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         tt_q       <= '0;
         unstable_q <= '0;
         match_q    <= 1'b0;
         sh_tt_q    <= '0;
         sh_unst_q  <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start && !bus.abort) begin
                  state_q   <= SETTLE;
                  row_q     <= '0;
                  cnt_q     <= '0;
                  drive_q   <= '0;
                  busy_q    <= 1'b1;
                  sh_tt_q   <= '0;
                  sh_unst_q <= '0;
               end
            end
            SETTLE: begin
               if (bus.abort) begin
                  state_q <= IDLE;
                  drive_q <= '0;
                  busy_q  <= 1'b0;
               end else begin
                  sh_tt_q   <= sh_tt_d;
                  sh_unst_q <= sh_unst_d;
                  if (!cnt_last_c) begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end else if (row_q != 3'd7) begin
                     row_q   <= row_q + 3'd1;
                     cnt_q   <= '0;
                     drive_q <= row_q + 3'd1;
                  end else begin
                     state_q    <= FINISH;
                     drive_q    <= '0;
                     busy_q     <= 1'b0;
                     done_q     <= 1'b1;
                     tt_q       <= sh_tt_d;
                     unstable_q <= sh_unst_d;
                     match_q    <= (sh_tt_d == EXPECTED_TT) && (sh_unst_d == 8'h00);
                  end
               end
            end
            FINISH: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
               drive_q <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in1      = drive_q[2];
   assign bus.in2      = drive_q[1];
   assign bus.in3      = drive_q[0];
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.tt       = tt_q;
   assign bus.unstable = unstable_q;
   assign bus.match    = match_q;

endmodule

// File: tb/tb_tt3_sweep_capture.sv
// Bench for tt3_sweep_capture: randomised gate functions and glitch rows
// against a row-level reference model of the expected result word.
module tb_tt3_sweep_capture;

   localparam int S = 4;

   logic clk;
   logic rst_n;
   logic [7:0] fn;
   logic       glitch;
   int         n_tests;
   int         n_fail;
   int         exp_tt;
   int         exp_unst;
   int         exp_match;

   tt3_sweep_capture_if bus ();

   tt3_sweep_capture dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // Gate under test: truth table fn, bit 7-row, optionally inverted for a glitch.
   assign bus.gate_out = glitch ^ fn[3'(~{bus.in1, bus.in2, bus.in3})];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_results(input string tag);
      check({tag, "_tt"},    int'(bus.tt),       exp_tt);
      check({tag, "_unst"},  int'(bus.unstable), exp_unst);
      check({tag, "_match"}, int'(bus.match),    exp_match);
   endtask

   // gm: rows (in tt bit order) whose raw gate output glitches for one cycle
   // so that the synced value flips only in the last cycle of that row.
   task automatic run_sweep(input logic [7:0] f, input logic [7:0] gm, input string tag);
      fn = f;
      @(negedge clk);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < S; c++) begin
            glitch = gm[7-r] && (c == 1);
            check({tag, "_in"},   int'({bus.in1, bus.in2, bus.in3}), r);
            check({tag, "_busy"}, int'(bus.busy), 1);
            check({tag, "_done"}, int'(bus.done), 0);
            if (c == 0) check_results({tag, "_hold"});
            tick();
         end
      end
      glitch = 1'b0;
      exp_tt    = int'(f ^ gm);
      exp_unst  = int'(gm);
      exp_match = int'(((f ^ gm) == 8'h64) && (gm == 8'h00));
      check({tag, "_donepulse"}, int'(bus.done), 1);
      check({tag, "_busyoff"},   int'(bus.busy), 0);
      check({tag, "_in_idle"},   int'({bus.in1, bus.in2, bus.in3}), 0);
      check_results(tag);
      tick();
      check({tag, "_doneclr"}, int'(bus.done), 0);
      check_results({tag, "_after"});
   endtask

   initial begin
      int done_cnt;
      int done_at[$];
      n_tests   = 0;
      n_fail    = 0;
      fn        = 8'h64;
      glitch    = 1'b0;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      rst_n     = 1'b0;
      exp_tt    = 0;
      exp_unst  = 0;
      exp_match = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", int'(bus.busy), 0);
      check("rst_done", int'(bus.done), 0);
      check("rst_in",   int'({bus.in1, bus.in2, bus.in3}), 0);
      check_results("rst");
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Reference gate, constant outputs, single-row glitch.
      run_sweep(8'h64, 8'h00, "g64");
      run_sweep(8'hFF, 8'h00, "ones");
      run_sweep(8'h00, 8'h00, "zeros");
      run_sweep(8'h64, 8'h10, "glitch3");

      // Abort in row 5 after a passing sweep: results preserved, no done.
      run_sweep(8'h64, 8'h00, "pre_abort");
      @(negedge clk);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (5 * S + 1) tick();
      check("abort_row", int'({bus.in1, bus.in2, bus.in3}), 5);
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      check("abort_busy", int'(bus.busy), 0);
      check("abort_in",   int'({bus.in1, bus.in2, bus.in3}), 0);
      done_cnt = 0;
      for (int k = 0; k < 40; k++) begin
         if (bus.done) done_cnt++;
         tick();
      end
      check("abort_nodone", done_cnt, 0);
      check_results("abort");

      // Abort in IDLE wins over a simultaneous start.
      @(negedge clk);
      bus.start = 1'b1;
      bus.abort = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.abort = 1'b0;
      check("idle_abort_busy", int'(bus.busy), 0);
      tick();
      check("idle_abort_busy2", int'(bus.busy), 0);

      // Start held high: back-to-back sweeps, each accepted in the IDLE cycle after done.
      fn = 8'h64;
      @(negedge clk);
      bus.start = 1'b1;
      for (int k = 1; k <= 104; k++) begin
         tick();
         if (bus.done) done_at.push_back(k);
         if (k == 34) check("held_idle_gap", int'(bus.busy), 0);
         if (k == 35) check("held_restart",  int'(bus.busy), 1);
      end
      bus.start = 1'b0;
      check("held_ndone", done_at.size(), 3);
      if (done_at.size() == 3) begin
         check("held_done0", done_at[0], 33);
         check("held_done1", done_at[1], 67);
         check("held_done2", done_at[2], 101);
      end
      check_results("held");
      // Drain the sweep the held start launched after the third done.
      done_cnt = 0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (bus.done) done_cnt++;
      end
      check("held_drain", done_cnt, 1);

      // Randomised gate functions with sparse glitch rows.
      for (int i = 0; i < 6; i++) begin
         logic [7:0] f;
         logic [7:0] gm;
         f  = 8'($urandom);
         gm = 8'($urandom & $urandom & $urandom);
         if (i == 2) begin
            f  = 8'h64;
            gm = 8'h00;
         end
         run_sweep(f, gm, $sformatf("rnd%0d", i));
      end

      // Asynchronous reset in the middle of row 2.
      run_sweep(8'h64, 8'h00, "pre_rst");
      @(negedge clk);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (2 * S + 1) tick();
      #2;
      rst_n = 1'b0;
      #1;
      exp_tt    = 0;
      exp_unst  = 0;
      exp_match = 0;
      check("mrst_busy", int'(bus.busy), 0);
      check("mrst_done", int'(bus.done), 0);
      check("mrst_in",   int'({bus.in1, bus.in2, bus.in3}), 0);
      check_results("mrst");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      run_sweep(8'h64, 8'h00, "post_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
